// File: rtl/tick_if.sv
// Control and status bundle for the tick generator timebase.
interface tick_if #(
    parameter int DIV_W      = 16,
    parameter int NUM_STAGES = 3,
    parameter int TS_W       = 32
);
    logic                  en;
    logic                  sync_clr;
    logic                  div_load;
    logic [DIV_W-1:0]      div_val;
    logic [NUM_STAGES:0]   tick;
    logic                  clk_div;
    logic [TS_W-1:0]       timestamp;
    logic [DIV_W-1:0]      div_cur;
    logic                  div_pending;

    modport master (
        output en, sync_clr, div_load, div_val,
        input  tick, clk_div, timestamp, div_cur, div_pending
    );

    modport slave (
        input  en, sync_clr, div_load, div_val,
        output tick, clk_div, timestamp, div_cur, div_pending
    );
endinterface

// File: rtl/tick_generator.sv
// Programmable timebase: base tick, cascaded decade ticks, square wave and
// base-tick timestamp. A new divisor is staged and only switched in at a
// period boundary so no short or long period is ever produced mid-count.
module tick_generator #(
    parameter int CLK_HZ     = 50000000,
    parameter int BASE_HZ    = 1000,
    parameter int DIV_W      = 16,
    parameter int NUM_STAGES = 3,
    parameter int TS_W       = 32
) (
    input  logic  clk,
    input  logic  rst,
    tick_if.slave bus
);
    localparam int               DEFAULT_DIV = CLK_HZ / BASE_HZ;
    localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN     = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);

    logic [DIV_W-1:0]                cnt_q, cnt_d;
    logic [NUM_STAGES-1:0][3:0]      dec_q, dec_d;
    logic [NUM_STAGES:0]             tick_q, tick_d;
    logic                            clk_div_q, clk_div_d;
    logic [TS_W-1:0]                 ts_q, ts_d;
    logic [DIV_W-1:0]                div_cur_q, div_cur_d;
    logic [DIV_W-1:0]                div_pend_q, div_pend_d;
    logic                            pending_q, pending_d;

    logic [DIV_W-1:0]                load_val;
    logic [DIV_W-1:0]                apply_val;
    logic                            apply_req;
    logic                            wrap0;
    logic                            carry;

    // Divisor staging and base-period terminal count. A load on the same
    // edge as a wrap is visible to the apply path directly.
    always_comb begin
        load_val  = (bus.div_val < DIV_MIN) ? DIV_MIN : bus.div_val;
        apply_val = bus.div_load ? load_val : div_pend_q;
        apply_req = bus.div_load | pending_q;
        // >= rather than == so a counter left above a shrunken divisor can never run away
        wrap0     = bus.en & (cnt_q >= (div_cur_q - DIV_ONE));
    end

    // Next-state for counter, decades, ticks, square wave and timestamp.
    always_comb begin
        cnt_d      = cnt_q;
        dec_d      = dec_q;
        tick_d     = '0;
        clk_div_d  = clk_div_q;
        ts_d       = ts_q;
        div_cur_d  = div_cur_q;
        div_pend_d = bus.div_load ? load_val : div_pend_q;
        pending_d  = apply_req;
        carry      = 1'b0;

        if (bus.sync_clr) begin
            cnt_d     = '0;
            dec_d     = '0;
            ts_d      = '0;
            clk_div_d = 1'b0;
            if (apply_req) begin
                div_cur_d = apply_val;
                pending_d = 1'b0;
            end
        end else if (!bus.en) begin
            // Frozen, but a staged divisor still goes in; its period starts fresh.
            if (apply_req) begin
                div_cur_d = apply_val;
                pending_d = 1'b0;
                cnt_d     = '0;
            end
        end else if (wrap0) begin
            cnt_d     = '0;
            ts_d      = ts_q + TS_W'(1);
            tick_d[0] = 1'b1;
            clk_div_d = 1'b0;
            if (apply_req) begin
                div_cur_d = apply_val;
                pending_d = 1'b0;
            end
            carry = 1'b1;
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (carry) begin
                    dec_d[k] = (dec_q[k] == 4'd9) ? 4'd0 : dec_q[k] + 4'd1;
                end
                carry       = carry & (dec_q[k] == 4'd9);
                tick_d[k+1] = carry;
            end
        end else begin
            cnt_d     = cnt_q + DIV_ONE;
            clk_div_d = (cnt_d >= (div_cur_q >> 1));
        end
    end

    // State registers; reset discards any staged divisor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            dec_q      <= '0;
            tick_q     <= '0;
            clk_div_q  <= 1'b0;
            ts_q       <= '0;
            div_cur_q  <= DIV_RST;
            div_pend_q <= DIV_RST;
            pending_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dec_q      <= dec_d;
            tick_q     <= tick_d;
            clk_div_q  <= clk_div_d;
            ts_q       <= ts_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.tick        = tick_q;
    assign bus.clk_div     = clk_div_q;
    assign bus.timestamp   = ts_q;
    assign bus.div_cur     = div_cur_q;
    assign bus.div_pending = pending_q;
endmodule

// File: tb/tb_tick_generator.sv
// Scoreboarded bench for tick_generator: a 32-bit and a 4-bit timestamp
// instance share one stimulus stream and one behavioural model.
module tb_tick_generator;
    localparam int DIV_W = 16;
    localparam int NS    = 2;

    logic clk;
    logic rst;

    tick_if #(.DIV_W(DIV_W), .NUM_STAGES(NS), .TS_W(32)) a ();
    tick_if #(.DIV_W(DIV_W), .NUM_STAGES(NS), .TS_W(4))  b ();

    assign b.en       = a.en;
    assign b.sync_clr = a.sync_clr;
    assign b.div_load = a.div_load;
    assign b.div_val  = a.div_val;

    tick_generator #(.CLK_HZ(1000), .BASE_HZ(100), .DIV_W(DIV_W), .NUM_STAGES(NS), .TS_W(32))
        dut_a (.clk(clk), .rst(rst), .bus(a));
    tick_generator #(.CLK_HZ(1000), .BASE_HZ(100), .DIV_W(DIV_W), .NUM_STAGES(NS), .TS_W(4))
        dut_b (.clk(clk), .rst(rst), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NS:0]     tick;
        logic            clk_div;
        longint unsigned count;
        int              div;
        logic            pending;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model: phase within current period, total base ticks since clear
    int              m_div;
    int              m_pend;
    bit              m_pending;
    int              m_phase;
    longint unsigned m_count;
    logic [NS:0]     m_tick;
    logic            m_clk;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_div = 10; m_pend = 10; m_pending = 0; m_phase = 0;
        m_count = 0; m_tick = '0; m_clk = 0;
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit l, input int v);
        exp_t x;
        int   lv;
        @(negedge clk);
        rst = r; a.en = e; a.sync_clr = c; a.div_load = l; a.div_val = DIV_W'(v);
        if (r) begin
            model_reset();
            #1;
            chk("rst_tick", a.tick, 0);
            chk("rst_clk_div", a.clk_div, 0);
            chk("rst_ts", a.timestamp, 0);
            chk("rst_div_cur", a.div_cur, 10);
            chk("rst_pending", a.div_pending, 0);
        end else begin
            lv = (v < 2) ? 2 : v;
            if (l) begin m_pend = lv; m_pending = 1; end
            if (c) begin
                m_phase = 0; m_count = 0; m_tick = '0; m_clk = 0;
                if (m_pending) begin m_div = m_pend; m_pending = 0; end
            end else if (!e) begin
                m_tick = '0;
                if (m_pending) begin m_div = m_pend; m_pending = 0; m_phase = 0; end
            end else if (m_phase == m_div - 1) begin
                m_phase = 0;
                m_count++;
                m_tick[0] = 1'b1;
                m_tick[1] = (m_count % 10 == 0);
                m_tick[2] = (m_count % 100 == 0);
                if (m_pending) begin m_div = m_pend; m_pending = 0; end
                m_clk = (m_phase >= m_div / 2);
            end else begin
                m_phase++;
                m_tick = '0;
                m_clk = (m_phase >= m_div / 2);
            end
        end
        x.tick = m_tick; x.clk_div = m_clk; x.count = m_count;
        x.div = m_div; x.pending = m_pending;
        q.push_back(x);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
    endtask

    task automatic wait_phase(input int p);
        int guard = 0;
        while (m_phase != p && guard < 300) begin
            step(0, 1, 0, 0, 0);
            guard++;
        end
        chk("wait_phase_timeout", guard < 300, 1);
    endtask

    // monitor: one expected record per clock edge, sampled just after the edge
    logic prev_t0 = 1'b0;
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("tick", a.tick, x.tick);
                chk("clk_div", a.clk_div, x.clk_div);
                chk("timestamp32", a.timestamp, x.count & 64'hFFFF_FFFF);
                chk("timestamp4", b.timestamp, x.count & 64'hF);
                chk("tick4", b.tick, x.tick);
                chk("div_cur", a.div_cur, longint'(x.div));
                chk("div_pending", a.div_pending, x.pending);
                if (a.tick[0]) chk("tick0_back_to_back", prev_t0, 0);
                prev_t0 = a.tick[0];
            end
        end
    end

    initial begin
        int g;
        rst = 1'b1; a.en = 0; a.sync_clr = 0; a.div_load = 0; a.div_val = '0;
        model_reset();

        repeat (3) step(1, 0, 0, 0, 0);
        run(1050);

        wait_phase(3);
        step(0, 1, 0, 1, 7);
        run(40);

        step(0, 1, 0, 1, 0);
        run(20);
        step(0, 1, 0, 1, 1);
        run(20);

        step(0, 1, 0, 1, 10);
        run(15);
        wait_phase(4);
        repeat (13) step(0, 0, 0, 0, 0);
        run(30);

        step(0, 1, 1, 0, 0);
        g = 0;
        while (!(m_count == 4 && m_phase == 6) && g < 200) begin
            step(0, 1, 0, 0, 0);
            g++;
        end
        chk("wait_ts4_cnt6_timeout", g < 200, 1);
        step(0, 1, 1, 0, 0);
        run(20);
        step(0, 1, 1, 1, 5);
        run(20);

        wait_phase(2);
        step(0, 1, 0, 1, 7);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        run(30);

        for (int i = 0; i < 3000; i++) begin
            bit r, e, c, l;
            r = ($urandom_range(0, 999) == 0);
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 49) == 0);
            l = e && ($urandom_range(0, 29) == 0);
            step(r, e, c, l, int'($urandom_range(0, 15)));
        end
        run(5);

        g = 0;
        while (q.size() > 0 && g < 20) begin
            @(posedge clk);
            g++;
        end
        #2;
        chk("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
